stage_execute_mdu: RTL
======================

// Module: stage_execute_mdu
// PURPOSE
//  Multi-cycle RV32M multiply/divide execute unit. Sits beside the single-cycle integer ALU in EX.
//  Uses a valid/ready handshake on input and output, so the pipeline stalls for exactly the busy time.
//  Holds one operation at a time. Results are XLEN wide. An optional tag travels with the operation for writeback.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  TAG_W  5   width of pass-through tag (rd index)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       kill in-flight op (branch mispredict/trap)
//  in_valid   in   1       op offered
//  in_ready   out  1       unit can accept; =1 only in IDLE
//  in_op      in   3       funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  in_rs1     in   XLEN    operand a (dividend/multiplicand)
//  in_rs2     in   XLEN    operand b (divisor/multiplier)
//  in_tag     in   TAG_W   tag, returned unchanged
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  XLEN    result
//  out_tag    out  TAG_W   tag of the result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_tag=0, counter=0.
//  Handshakes: input fires on in_valid&in_ready. Output fires on out_valid&out_ready.
//   While out_valid=1 and out_ready=0, out_data and out_tag are held stable.
//  FSM IDLE->CALC: on accept, latch op and tag. Latch |a|,|b| as needed by signedness, plus sign flags.
//   MULH/DIV/REM: both operands signed. MULHSU: rs1 signed. Others: unsigned.
//  FSM IDLE->DONE: a special case is accepted (see below), or FAST_MUL_EN is defined and the op is a multiply.
//  CALC: one bit per cycle for XLEN cycles; counter runs 0..XLEN-1.
//   Multiply: shift-add into a 2*XLEN accumulator.
//   Divide: restoring divide into quotient and remainder.
//  CALC->DONE: after the last iteration, apply the sign fix-up in the same cycle.
//   Product is negated if sign_a^sign_b (for the signed operand set).
//   Quotient is negated if sign_a^sign_b. Remainder takes sign_a.
//  Result select: MUL=product[XLEN-1:0]. MULH/MULHSU/MULHU=product[2XLEN-1:XLEN]. DIV/DIVU=quotient. REM/REMU=remainder.
//  Latency: accept at cycle T gives out_valid at T+XLEN+1. Special cases give out_valid at T+1.
//  DONE->IDLE: on output fire. in_ready=1 the next cycle; no same-cycle accept in DONE.
//  Special cases, no iteration:
//   Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   Signed overflow (rs1=MIN, rs2=-1): DIV -> MIN; REM -> 0.
//  flush: highest priority in every state.
//   Next cycle: state=IDLE, out_valid=0, no result is emitted.
//   An in_valid in the same cycle as flush is not accepted.
//  Reset mid-operation: the op is lost and all outputs return to reset values immediately.
//  All arithmetic is modulo 2^XLEN; intermediate values are 2*XLEN (mul) or XLEN+1 (div remainder).
// CONFIGURATION
//  STAGE_EXECUTE_MDU_FAST_MUL_EN
//   Defined: MUL/MULH/MULHSU/MULHU compute with one combinational 2XLEN product at accept.
//    They go IDLE->DONE with out_valid at T+1. Divide is unchanged.
//   Undefined: all multiplies are iterative with XLEN+1 latency. No `*` operator is instantiated.
// TESTING (XLEN=32, FAST_MUL_EN undefined unless stated)
//  1 MUL 7 x 0xFFFFFFFD, accept at T -> out_data=0xFFFFFFEB at T+33; in_ready=0 during T+1..T+33.
//  2 MULH 0x80000000^2 -> 0x40000000.
//    MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU same operands -> 0x7FFFFFFC.
//  4 DIV 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5.
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0.
//  5 out_ready=0 for 5 cycles after out_valid -> data and tag stable, in_ready=0.
//    Then 1 cycle out_ready=1 -> in_ready=1 next cycle.
//  6 flush at cycle 10 of CALC -> out_valid never rises, in_ready=1 next cycle.
//    rst_n pulse mid-CALC -> outputs reset asynchronously.
//    With FAST_MUL_EN: MUL 7 x 3 -> 21 at T+1.

Source files
------------

// File: rtl/stage_execute_mdu_if.sv
// rtl/stage_execute_mdu_if.sv - issue/result handshake bundle between EX pipeline and the MDU
interface stage_execute_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/stage_execute_mdu.sv
// rtl/stage_execute_mdu.sv - multi-cycle RV32M multiply/divide unit, one op in flight
// Optional single-cycle multiply: define STAGE_EXECUTE_MDU_FAST_MUL_EN.
module stage_execute_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  stage_execute_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_d;
  logic [2:0]         op_q;
  logic               sign_a, sign_b;
  logic [CW-1:0]      counter;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    opb;
  logic [XLEN-1:0]    data_q;
  logic [TAG_W-1:0]   tag_q;

  function automatic logic [XLEN-1:0] result_sel(input logic [2:0] op,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic [XLEN-1:0] quot,
                                                 input logic [XLEN-1:0] rem);
    case (op)
      3'd0:             return prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: return prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       return quot;
      default:          return rem;
    endcase
  endfunction

  logic            accept, is_div, sgn_a_in, sgn_b_in, div_zero, div_ovf, special, is_fast, last;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign accept   = bus.in_valid && (state == IDLE) && !bus.flush;
  assign is_div   = bus.in_op[2];
  assign sgn_a_in = ((bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
                     (bus.in_op == 3'd4) || (bus.in_op == 3'd6)) && bus.in_rs1[XLEN-1];
  assign sgn_b_in = ((bus.in_op == 3'd1) || (bus.in_op == 3'd4) ||
                     (bus.in_op == 3'd6)) && bus.in_rs2[XLEN-1];
  assign abs_a    = sgn_a_in ? -bus.in_rs1 : bus.in_rs1;
  assign abs_b    = sgn_b_in ? -bus.in_rs2 : bus.in_rs2;
  assign div_zero = is_div && (bus.in_rs2 == '0);
  assign div_ovf  = ((bus.in_op == 3'd4) || (bus.in_op == 3'd6)) &&
                    (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_rs2 == '1);
  assign special  = div_zero || div_ovf;
  // in_op[1] separates REM/REMU from DIV/DIVU
  assign special_res = div_zero ? (bus.in_op[1] ? bus.in_rs1 : '1)
                                : (bus.in_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef STAGE_EXECUTE_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_mag  = abs_a * abs_b;
  assign fast_prod = (sgn_a_in ^ sgn_b_in) ? -fast_mag : fast_mag;
  assign fast_res  = result_sel(bus.in_op, fast_prod, '0, '0);
  assign is_fast   = !is_div;
`else
  assign is_fast   = 1'b0;
`endif

  // Shift-add multiply: acc = {partial sum, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend shifting into quotient}
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next, acc_next;
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_diff  = div_shift[XLEN-1:0] - opb;
  assign div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc[XLEN-2:0], div_ge};
  assign acc_next  = op_q[2] ? div_next : mul_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;
  assign prod_fix  = (sign_a ^ sign_b) ? -acc_next : acc_next;
  assign quot_fix  = (sign_a ^ sign_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
  assign rem_fix   = sign_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
  assign final_res = result_sel(op_q, prod_fix, quot_fix, rem_fix);
  assign last      = (counter == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    bus.in_ready = (state == IDLE);
    bus.out_valid = (state == DONE);
    case (state)
      IDLE:    if (accept) state_d = (special || is_fast) ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      counter <= '0;
      acc     <= '0;
      opb     <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else if (bus.flush) begin
      counter <= '0;
    end else if (accept) begin
      op_q    <= bus.in_op;
      tag_q   <= bus.in_tag;
      sign_a  <= sgn_a_in;
      sign_b  <= sgn_b_in;
      counter <= '0;
      if (special) begin
        data_q <= special_res;
`ifdef STAGE_EXECUTE_MDU_FAST_MUL_EN
      end else if (is_fast) begin
        data_q <= fast_res;
`endif
      end else begin
        acc <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
        opb <= is_div ? abs_b : abs_a;
      end
    end else if (state == CALC) begin
      acc     <= acc_next;
      counter <= counter + 1'b1;
      if (last) data_q <= final_res;
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_tag  = tag_q;
endmodule
